// File: rtl/multibyte_add_sequencer_pkg.sv
// rtl/multibyte_add_sequencer_pkg.sv - shared constants, state type and index-width helper
package add_seq_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Smallest r with 2**r >= n; used to size the byte index.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) begin
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/multibyte_add_sequencer_if.sv
// rtl/multibyte_add_sequencer_if.sv - operand, result and adder-side signals of the sequencer
interface multibyte_add_sequencer_if #(
  parameter int NBYTES = 4
);
  import add_seq_pkg::*;

  // operand request
  logic                       in_valid;
  logic                       in_ready;
  logic [BYTE_W*NBYTES-1:0]   op_a;
  logic [BYTE_W*NBYTES-1:0]   op_b;
  logic                       cin;

  // result
  logic                       out_valid;
  logic                       out_ready;
  logic [BYTE_W*NBYTES-1:0]   sum;
  logic                       cout;

  // registered 8-bit adder stage
  logic [BYTE_W-1:0]          add_a;
  logic [BYTE_W-1:0]          add_b;
  logic                       add_cin;
  logic [BYTE_W-1:0]          add_sout;
  logic                       add_cout;

  // Environment side: supplies operands, consumes results, hosts the adder.
  modport master (
    output in_valid, op_a, op_b, cin, out_ready, add_sout, add_cout,
    input  in_ready, out_valid, sum, cout, add_a, add_b, add_cin
  );

  // Sequencer side.
  modport slave (
    input  in_valid, op_a, op_b, cin, out_ready, add_sout, add_cout,
    output in_ready, out_valid, sum, cout, add_a, add_b, add_cin
  );

endinterface

// File: rtl/multibyte_add_sequencer.sv
// rtl/multibyte_add_sequencer.sv - feeds a registered 8-bit adder LSB-first and assembles the wide sum
module multibyte_add_sequencer
  import add_seq_pkg::*;
#(
  parameter int NBYTES = 4
) (
  input logic                    clk,
  input logic                    reset,
  multibyte_add_sequencer_if.slave bus
);

  localparam int             IW   = clog2(NBYTES);
  localparam logic [IW-1:0]  LAST = IW'(NBYTES - 1);

  state_t            state;
  logic [BYTE_W-1:0] a_lat [NBYTES];
  logic [BYTE_W-1:0] b_lat [NBYTES];
  logic              cin_lat;
  logic [IW-1:0]     idx;
  logic [IW-1:0]     idx_next;

  // v1/c1: a byte sits in the adder input register; v2/c2: its result sits in the adder output register.
  logic              v1;
  logic [IW-1:0]     c1;
  logic              v2;
  logic [IW-1:0]     c2;

  logic [BYTE_W-1:0] sum_q [NBYTES];
  logic              cout_q;
  logic              in_ready_q;
  logic              out_valid_q;
  logic [BYTE_W-1:0] add_a_q;
  logic [BYTE_W-1:0] add_b_q;

  assign idx_next = idx + 1'b1;

  // Control FSM, issue counter, pipeline tracker and result capture.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      cin_lat     <= 1'b0;
      idx         <= '0;
      v1          <= 1'b0;
      c1          <= '0;
      v2          <= 1'b0;
      c2          <= '0;
      cout_q      <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      add_a_q     <= '0;
      add_b_q     <= '0;
      for (int k = 0; k < NBYTES; k++) begin
        a_lat[k] <= '0;
        b_lat[k] <= '0;
        sum_q[k] <= '0;
      end
    end else begin
      // The adder output register always holds whatever was in its input register one edge ago.
      v2 <= v1;
      c2 <= c1;
      v1 <= 1'b0;

      if (v2) begin
        sum_q[c2] <= bus.add_sout;
        if (c2 == LAST) begin
          cout_q <= bus.add_cout;
        end
      end

      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            for (int k = 0; k < NBYTES; k++) begin
              a_lat[k] <= bus.op_a[k*BYTE_W +: BYTE_W];
              b_lat[k] <= bus.op_b[k*BYTE_W +: BYTE_W];
            end
            cin_lat    <= bus.cin;
            idx        <= '0;
            add_a_q    <= bus.op_a[BYTE_W-1:0];
            add_b_q    <= bus.op_b[BYTE_W-1:0];
            in_ready_q <= 1'b0;
            state      <= ISSUE;
          end
        end
        ISSUE: begin
          // The byte currently presented is captured by the adder at this edge.
          v1 <= 1'b1;
          c1 <= idx;
          if (idx == LAST) begin
            add_a_q <= '0;
            add_b_q <= '0;
            state   <= DRAIN;
          end else begin
            idx     <= idx_next;
            add_a_q <= a_lat[idx_next];
            add_b_q <= b_lat[idx_next];
          end
        end
        DRAIN: begin
          if (v2 && (c2 == LAST)) begin
            out_valid_q <= 1'b1;
            state       <= DONE;
          end
        end
        DONE: begin
          // New operands are not looked at here; they are taken once back in IDLE.
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Carry into the adder's ripple chain: operand cin for byte 0, else the previous byte's carry.
  always_comb begin
    bus.add_cin = 1'b0;
    if (v1) begin
      bus.add_cin = (c1 == '0) ? cin_lat : bus.add_cout;
    end
  end

  // Flatten the collected sum bytes onto the result bus.
  always_comb begin
    bus.sum = '0;
    for (int k = 0; k < NBYTES; k++) begin
      bus.sum[k*BYTE_W +: BYTE_W] = sum_q[k];
    end
  end

  assign bus.cout      = cout_q;
  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.add_a     = add_a_q;
  assign bus.add_b     = add_b_q;

endmodule

// File: tb/tb_multibyte_add_sequencer.sv
// tb/tb_multibyte_add_sequencer.sv - self-checking bench with a behavioural registered adder and reference sum
module tb_multibyte_add_sequencer;
  import add_seq_pkg::*;

  localparam int NB = 4;
  localparam int W  = NB * BYTE_W;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   failures = 0;

  multibyte_add_sequencer_if #(.NBYTES(NB)) bus ();

  multibyte_add_sequencer #(.NBYTES(NB)) dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Registered 8-bit adder: operands captured at one edge, sum/carry registered at the next.
  logic [BYTE_W-1:0] ra, rb;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ra <= '0;
      rb <= '0;
      bus.add_sout <= '0;
      bus.add_cout <= 1'b0;
    end else begin
      {bus.add_cout, bus.add_sout} <= {1'b0, ra} + {1'b0, rb} + {{BYTE_W{1'b0}}, bus.add_cin};
      ra <= bus.add_a;
      rb <= bus.add_b;
    end
  end

  function automatic logic [W:0] ref_add(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
    return {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(output int lat);
    lat = -1;
    for (int n = 1; n <= 20; n++) begin
      if (lat < 0) begin
        tick();
        if (bus.out_valid === 1'b1) lat = n;
      end
    end
  endtask

  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic c, input int hold,
                       output logic rdy_before, output int lat, output logic [W-1:0] s,
                       output logic co, output logic idle_after);
    rdy_before   = bus.in_ready;
    bus.op_a     = a;
    bus.op_b     = b;
    bus.cin      = c;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    wait_done(lat);
    s  = bus.sum;
    co = bus.cout;
    repeat (hold) tick();
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    idle_after = (bus.out_valid === 1'b0) && (bus.in_ready === 1'b1);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) begin
      bus.in_valid  = 1'($urandom_range(0, 1));
      bus.out_ready = 1'($urandom_range(0, 1));
      bus.op_a      = W'($urandom);
      bus.op_b      = W'($urandom);
      bus.cin       = 1'($urandom_range(0, 1));
      tick();
    end
    checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready: got %b expected 1", bus.in_ready); end
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid: got %b expected 0", bus.out_valid); end
    checks++; if (bus.sum !== '0) begin failures++; $display("FAIL reset_sum: got %h expected 0", bus.sum); end
    checks++; if (bus.cout !== 1'b0) begin failures++; $display("FAIL reset_cout: got %b expected 0", bus.cout); end
    checks++; if (bus.add_a !== '0 || bus.add_b !== '0) begin failures++; $display("FAIL reset_add_ab: got %h/%h expected 0/0", bus.add_a, bus.add_b); end
    checks++; if (bus.add_cin !== 1'b0) begin failures++; $display("FAIL reset_add_cin: got %b expected 0", bus.add_cin); end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_directed();
    logic [W-1:0] ta [4] = '{32'h000000FF, 32'hFFFFFFFF, 32'h00FF00FF, 32'h80000000};
    logic [W-1:0] tb [4] = '{32'h00000001, 32'h00000000, 32'h00010001, 32'h80000000};
    logic         tc [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
    logic [W-1:0] es [4] = '{32'h00000100, 32'h00000000, 32'h01000100, 32'h00000000};
    logic         ec [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic rdy, co, idle;
    logic [W-1:0] s;
    int lat;
    for (int i = 0; i < 4; i++) begin
      do_op(ta[i], tb[i], tc[i], 1, rdy, lat, s, co, idle);
      checks++; if (rdy !== 1'b1) begin failures++; $display("FAIL directed_ready[%0d]: got %b expected 1", i, rdy); end
      checks++; if (lat != NB + 2) begin failures++; $display("FAIL directed_latency[%0d]: got %0d expected %0d", i, lat, NB + 2); end
      checks++; if (s !== es[i]) begin failures++; $display("FAIL directed_sum[%0d]: got %h expected %h", i, s, es[i]); end
      checks++; if (co !== ec[i]) begin failures++; $display("FAIL directed_cout[%0d]: got %b expected %b", i, co, ec[i]); end
      checks++; if (idle !== 1'b1) begin failures++; $display("FAIL directed_idle[%0d]: got %b expected 1", i, idle); end
    end
  endtask

  task automatic test_random();
    logic [W-1:0] a, b, s;
    logic c, rdy, co, idle;
    logic [W:0] r;
    int lat;
    for (int i = 0; i < 16; i++) begin
      a = W'($urandom);
      b = W'($urandom);
      if (i % 4 == 0) b = ~a;
      c = 1'($urandom_range(0, 1));
      r = ref_add(a, b, c);
      do_op(a, b, c, int'($urandom_range(0, 3)), rdy, lat, s, co, idle);
      checks++; if (lat != NB + 2) begin failures++; $display("FAIL random_latency[%0d]: got %0d expected %0d", i, lat, NB + 2); end
      checks++; if (s !== r[W-1:0] || co !== r[W]) begin
        failures++; $display("FAIL random_result[%0d]: %h+%h+%b got %b_%h expected %b_%h", i, a, b, c, co, s, r[W], r[W-1:0]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] a, b, s;
    logic c, rdy, co, idle;
    logic [W:0] r;
    int lat;
    for (int i = 0; i < 4; i++) begin
      a = W'($urandom);
      b = W'($urandom);
      c = 1'($urandom_range(0, 1));
      r = ref_add(a, b, c);
      do_op(a, b, c, 0, rdy, lat, s, co, idle);
      checks++; if (rdy !== 1'b1 || idle !== 1'b1) begin failures++; $display("FAIL b2b_handshake[%0d]: got ready %b idle %b expected 1 1", i, rdy, idle); end
      checks++; if (lat != NB + 2 || s !== r[W-1:0] || co !== r[W]) begin
        failures++; $display("FAIL b2b_result[%0d]: got lat %0d %b_%h expected lat %0d %b_%h", i, lat, co, s, NB + 2, r[W], r[W-1:0]);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [W-1:0] a, b, a2, b2;
    logic c, c2;
    logic [W:0] r, r2;
    int lat;
    a = W'($urandom); b = W'($urandom); c = 1'($urandom_range(0, 1));
    r = ref_add(a, b, c);
    bus.op_a = a; bus.op_b = b; bus.cin = c; bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    wait_done(lat);
    checks++; if (lat != NB + 2) begin failures++; $display("FAIL bp_latency: got %0d expected %0d", lat, NB + 2); end
    for (int k = 0; k < 5; k++) begin
      bus.in_valid = (k == 1);
      if (k == 1) begin
        bus.op_a = W'($urandom); bus.op_b = W'($urandom); bus.cin = 1'($urandom_range(0, 1));
      end
      tick();
      checks++; if (bus.out_valid !== 1'b1 || bus.sum !== r[W-1:0] || bus.cout !== r[W] || bus.in_ready !== 1'b0) begin
        failures++; $display("FAIL bp_hold[%0d]: got v%b r%b %b_%h expected v1 r0 %b_%h", k, bus.out_valid, bus.in_ready, bus.cout, bus.sum, r[W], r[W-1:0]);
      end
    end
    a2 = W'($urandom); b2 = W'($urandom); c2 = 1'($urandom_range(0, 1));
    r2 = ref_add(a2, b2, c2);
    bus.op_a = a2; bus.op_b = b2; bus.cin = c2;
    bus.in_valid = 1'b1; bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    checks++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.add_a !== '0) begin
      failures++; $display("FAIL bp_release: got v%b r%b add_a %h expected v0 r1 add_a 00", bus.out_valid, bus.in_ready, bus.add_a);
    end
    tick();
    bus.in_valid = 1'b0;
    checks++; if (bus.in_ready !== 1'b0 || bus.add_a !== a2[BYTE_W-1:0]) begin
      failures++; $display("FAIL bp_accept_next: got r%b add_a %h expected r0 add_a %h", bus.in_ready, bus.add_a, a2[BYTE_W-1:0]);
    end
    wait_done(lat);
    checks++; if (lat != NB + 2 || bus.sum !== r2[W-1:0] || bus.cout !== r2[W]) begin
      failures++; $display("FAIL bp_next_result: got lat %0d %b_%h expected lat %0d %b_%h", lat, bus.cout, bus.sum, NB + 2, r2[W], r2[W-1:0]);
    end
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset_mid_op();
    logic [W-1:0] s;
    logic rdy, co, idle, seen;
    int lat;
    bus.op_a = W'($urandom); bus.op_b = W'($urandom); bus.cin = 1'($urandom_range(0, 1));
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    checks++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.sum !== '0 || bus.add_a !== '0) begin
      failures++; $display("FAIL midreset_values: got v%b r%b sum %h add_a %h expected v0 r1 sum 0 add_a 0", bus.out_valid, bus.in_ready, bus.sum, bus.add_a);
    end
    tick();
    tick();
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (12) begin
      tick();
      if (bus.out_valid !== 1'b0) seen = 1'b1;
    end
    checks++; if (seen !== 1'b0) begin failures++; $display("FAIL midreset_no_output: got out_valid seen %b expected 0", seen); end
    do_op(32'h12345678, 32'h11111111, 1'b0, 0, rdy, lat, s, co, idle);
    checks++; if (rdy !== 1'b1 || lat != NB + 2) begin failures++; $display("FAIL midreset_next_timing: got ready %b lat %0d expected 1 %0d", rdy, lat, NB + 2); end
    checks++; if (s !== 32'h23456789 || co !== 1'b0) begin failures++; $display("FAIL midreset_next_result: got %b_%h expected 0_23456789", co, s); end
  endtask

  initial begin
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.op_a      = '0;
    bus.op_b      = '0;
    bus.cin       = 1'b0;
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_backpressure();
    test_reset_mid_op();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/multibyte_add_sequencer.md
Name: multibyte_add_sequencer

Overview:
- Controller that sits directly upstream of the registered 8-bit adder stage and consumes its registered sum and carry outputs.
- Accepts two NBYTES-wide operands over a valid/ready handshake.
- Issues one byte pair per cycle to the adder, LSB first, and chains the adder's registered carry into its carry input.
- Collects the sum bytes and presents the full-width sum and final carry over a valid/ready output handshake.

Parameters:
- NBYTES, 4, number of 8-bit limbs per operand (legal range 2..16).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset. The integration wrapper ties the adder's reset to its active-high equivalent.
- in_valid  input  1  operand request.
- in_ready  output  1  block can accept operands.
- op_a  input  8*NBYTES  operand A.
- op_b  input  8*NBYTES  operand B.
- cin  input  1  carry-in for byte 0.
- out_valid  output  1  result available.
- out_ready  input  1  consumer accepts result.
- sum  output  8*NBYTES  result.
- cout  output  1  carry out of the MSB byte.
- add_a  output  8  byte to adder A input.
- add_b  output  8  byte to adder B input.
- add_cin  output  1  adder carry-in (combinational into its ripple chain).
- add_sout  input  8  adder registered sum.
- add_cout  input  1  adder registered carry.

Behaviour:
- Adder timing model: add_a/add_b are captured at edge k. add_cin must be stable between edges k and k+1. add_sout/add_cout are valid after edge k+1.
- Reset (asynchronous, active-low): state=IDLE, in_ready=1, out_valid=0, sum=0, cout=0, add_a=add_b=0, add_cin=0, all counters and pipeline flags cleared.
- States: IDLE, ISSUE, DRAIN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid at edge e0: latch op_a, op_b, cin; issue index i=0; go to ISSUE.
- ISSUE:
  - add_a/add_b = latched byte i.
  - Each edge: i++ and shift pipeline flags. v1/c1 mark the byte held in the adder input register; v2/c2 mark the byte held in the adder output register.
  - After byte NBYTES-1 is issued, go to DRAIN.
- add_cin: equals latched cin when v1 && c1==0; equals add_cout when v1 && c1>0; otherwise 0.
- Sum capture: when v2, sum byte c2 <= add_sout at the next edge.
- Capture of byte NBYTES-1 also sets cout <= add_cout; state moves DRAIN -> DONE and out_valid=1.
- Latency: out_valid rises exactly NBYTES+2 cycles after the accept edge e0 (6 cycles for NBYTES=4).
- Idle drive: add_a/add_b are driven 0 outside ISSUE.
- DONE:
  - out_valid held; sum and cout stable until out_valid && out_ready at an edge, then go to IDLE.
  - in_ready=0 in every state except IDLE.
  - in_valid outside IDLE is ignored; there is no queuing.
- Simultaneous events: out_ready and in_valid in the same DONE cycle returns to IDLE only; new operands are accepted the following cycle.
- Reset mid-operation: immediate return to reset values. The partial sum is discarded and no out_valid is produced for the aborted operation.
- Width rule: the sum is modulo 2^(8*NBYTES); the carry out of byte NBYTES-1 goes only to cout.

Decomposition:
- Shared package add_seq_pkg holds:
  - BYTE_W=8.
  - The state enum (IDLE, ISSUE, DRAIN, DONE).
  - The index width function clog2(NBYTES).
- No internal sub-module: the issue counter and the v1/v2 pipeline tracker stay inline.
- The adder is instantiated next to this block in the wrapper multibyte_adder_sys, not inside it.

Test Plan:
- Reset: hold reset low 3 cycles with random inputs -> in_ready=1, out_valid=0, sum=0, cout=0, add_a=add_b=0, add_cin=0.
- Single carry: op_a=0x000000FF, op_b=0x00000001, cin=0 -> sum=0x00000100, cout=0, out_valid exactly 6 cycles after accept.
- Full ripple: op_a=0xFFFFFFFF, op_b=0x00000000, cin=1 -> sum=0x00000000, cout=1.
- Alternating carry: op_a=0x00FF00FF, op_b=0x00010001, cin=0 -> sum=0x01000100, cout=0. A second operation, 0x80000000+0x80000000, gives sum=0, cout=1.
- Backpressure: out_ready low 5 cycles after out_valid, with in_valid pulsed -> sum/cout stable, in_ready=0, pulse ignored. Then out_ready=1 -> IDLE, and the next op is accepted one cycle later.
- Reset mid-op: assert reset 2 cycles after accept -> no out_valid for that op. After release, 0x12345678+0x11111111, cin=0 -> sum=0x23456789, cout=0.
